mult_cpa_stage: RTL and testbench
=================================

Name: mult_cpa_stage

Overview:
- Two-stage pipelined carry-propagate adder directly downstream of the multiplier's partial-product carry-save reduction tree.
- Consumes the redundant sum/carry vector pair and the sign-extension-suppression flag, and produces the binary mantissa product for the normalizer and rounder.
- The addition is split into a low half and a high half, with the carry registered between them, to cut the critical path.
- Has valid/ready handshakes on both sides and supports stalls and flush.

Parameters:
- PARM_MANT, 23, stored mantissa width; operand vectors are 2*PARM_MANT+3 bits, product is 2*PARM_MANT+2 bits.
- PARM_LOW_W, PARM_MANT+1, bit width of the low-half adder in stage 1; the high half is the remaining 2*PARM_MANT+3-PARM_LOW_W bits.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  synchronous pipeline clear.
- valid_i  in  1  input vectors valid.
- ready_o  out  1  stage can accept input.
- wallace_sum_i  in  2*PARM_MANT+3  CSA sum vector.
- wallace_carry_i  in  2*PARM_MANT+3  CSA carry vector, already aligned.
- suppression_sign_extension_i  in  1  tree discarded a sign-extension carry.
- valid_o  out  1  product valid.
- ready_i  in  1  downstream accepts product.
- product_o  out  2*PARM_MANT+2  binary product.
- product_msb_o  out  1  equals product_o[2*PARM_MANT+1]; normalization hint.
- carry_drop_o  out  1  bit 2*PARM_MANT+2 of the raw sum was nonzero and was discarded.

Behaviour:
- Arithmetic: raw = (wallace_sum_i + wallace_carry_i) mod 2^(2*PARM_MANT+3).
  - product_o = raw[2*PARM_MANT+1:0].
  - carry_drop_o = raw[2*PARM_MANT+2] AND NOT suppression_sign_extension_i.
  - When suppression is asserted, the top bit is a known artefact and is silently discarded.
- Stage 1, on handshake (valid_i && ready_o), registers:
  - low sum = sum[PARM_LOW_W-1:0] + carry[PARM_LOW_W-1:0] and its carry-out;
  - the unmodified high halves of both vectors;
  - the suppression flag;
  - s1_valid is set.
- Stage 2, on advance, registers:
  - high = sum_hi + carry_hi + s1_cout, plus the stored low result;
  - the flag-derived carry_drop;
  - s2_valid is set.
- Latency: 2 cycles from accepted input to valid_o with no stall. Throughput: 1 result per cycle.
- Flow control:
  - s2 advances when s1_valid && (!s2_valid || ready_i).
  - ready_o = !s1_valid || s2 advance.
  - s2_valid clears when valid_o && ready_i and no new s1 data enters.
  - valid_o = s2_valid.
- Outputs stay stable while valid_o=1 and ready_i=0. No combinational path from valid_i to valid_o.
- Stall with both stages full: ready_o=0, contents held, no data loss or duplication.
- Simultaneous accept and drain: both stages shift in the same cycle, with no bubble.
- flush_i=1: s1_valid and s2_valid cleared next edge; input offered in the same cycle is dropped. Flush has priority over handshake.
- Reset: valid_o=0, product_o=0, product_msb_o=0, carry_drop_o=0, ready_o=1 after the reset edge. All data registers are cleared. Reset mid-operation discards in-flight data.
- Data registers load only on advance, to avoid gratuitous toggling.

Optional Feature:
- Macro MULT_CPA_STICKY_EN.
- When defined:
  - adds output sticky_o (1 bit) = OR of product_o[PARM_MANT-1:0], registered with the product and cleared on reset and flush;
  - the low-half OR-reduction is computed in stage 1, so the late high half is not lengthened.
- When undefined: port absent, no logic added.

Test Plan:
- Values below use PARM_MANT=23 (49-bit operand vectors).
- Pass-through: sum=0x0400000000000, carry=0, suppression=0, ready_i=1 -> product_o=0x400000000000, product_msb_o=0, carry_drop_o=0, valid_o 2 cycles after accept.
- Cross-half carry: sum=0x0000000FFFFFF, carry=0x0000000000001 -> product_o=0x000001000000 (carry propagates through the stage boundary).
- Wrap/suppression: sum=0x1FFFFFFFFFFFF, carry=1 -> product_o=0; then sum=0x1000000000000, carry=0:
  - with suppression=1 -> carry_drop_o=0;
  - with suppression=0 -> carry_drop_o=1.
- Backpressure: stream 4 consecutive inputs with ready_i=0.
  - Exactly 2 are accepted, then ready_o=0.
  - valid_o holds the first product stable.
  - After ready_i=1, all 4 products emerge in order, with no loss or duplication.
- Flush/reset: 2 items in flight, assert flush_i one cycle -> valid_o=0 next cycle, nothing emitted. Repeat with rst_i mid-stream -> all outputs 0, ready_o=1.
- Sticky (macro defined): product low 23 bits 0x000001 -> sticky_o=1; low 23 bits 0 -> sticky_o=0.

Source files
------------

// File: rtl/mult_cpa_stage.sv
// rtl/mult_cpa_stage.sv - two-stage pipelined carry-propagate adder after the multiplier CSA tree
// Optional sticky output enabled by defining MULT_CPA_STICKY_EN.
module mult_cpa_stage #(
   parameter int PARM_MANT  = 23,
   parameter int PARM_LOW_W = PARM_MANT + 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [2*PARM_MANT+2:0]   wallace_sum_i,
   input  logic [2*PARM_MANT+2:0]   wallace_carry_i,
   input  logic                     suppression_sign_extension_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [2*PARM_MANT+1:0]   product_o,
   output logic                     product_msb_o,
   output logic                     carry_drop_o
`ifdef MULT_CPA_STICKY_EN
   ,
   output logic                     sticky_o
`endif
);

   localparam int W    = 2*PARM_MANT + 3;
   localparam int HI_W = W - PARM_LOW_W;
   localparam int PW   = W - 1;

   logic                  s1_valid_q, s1_valid_d;
   logic [PARM_LOW_W-1:0] s1_lo_q;
   logic                  s1_cout_q;
   logic [HI_W-1:0]       s1_sum_hi_q;
   logic [HI_W-1:0]       s1_car_hi_q;
   logic                  s1_supp_q;

   logic                  s2_valid_q, s2_valid_d;
   logic [PW-1:0]         s2_prod_q;
   logic                  s2_drop_q;

   logic                  s2_adv;
   logic                  accept;
   logic [PARM_LOW_W:0]   lo_sum;
   logic [HI_W-1:0]       hi_sum;
   logic [W-1:0]          raw;

   assign s2_adv  = s1_valid_q && (!s2_valid_q || ready_i);
   assign ready_o = !s1_valid_q || s2_adv;
   assign accept  = valid_i && ready_o && !flush_i;

   assign lo_sum = {1'b0, wallace_sum_i[PARM_LOW_W-1:0]}
                 + {1'b0, wallace_carry_i[PARM_LOW_W-1:0]};
   assign hi_sum = s1_sum_hi_q + s1_car_hi_q + {{(HI_W-1){1'b0}}, s1_cout_q};
   assign raw    = {hi_sum, s1_lo_q};

   always_comb begin
      s1_valid_d = s1_valid_q;
      if (flush_i)
         s1_valid_d = 1'b0;
      else if (accept)
         s1_valid_d = 1'b1;
      else if (s2_adv)
         s1_valid_d = 1'b0;
   end

   // s2 empties only when its product is taken and nothing moves up behind it
   always_comb begin
      s2_valid_d = s2_valid_q;
      if (flush_i)
         s2_valid_d = 1'b0;
      else if (s2_adv)
         s2_valid_d = 1'b1;
      else if (ready_i)
         s2_valid_d = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q  <= 1'b0;
         s1_lo_q     <= '0;
         s1_cout_q   <= 1'b0;
         s1_sum_hi_q <= '0;
         s1_car_hi_q <= '0;
         s1_supp_q   <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_prod_q   <= '0;
         s2_drop_q   <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (accept) begin
            s1_lo_q     <= lo_sum[PARM_LOW_W-1:0];
            s1_cout_q   <= lo_sum[PARM_LOW_W];
            s1_sum_hi_q <= wallace_sum_i[W-1:PARM_LOW_W];
            s1_car_hi_q <= wallace_carry_i[W-1:PARM_LOW_W];
            s1_supp_q   <= suppression_sign_extension_i;
         end
         if (s2_adv && !flush_i) begin
            s2_prod_q <= raw[PW-1:0];
            s2_drop_q <= raw[W-1] & ~s1_supp_q;
         end
      end
   end

`ifdef MULT_CPA_STICKY_EN
   // low product bits all live in the low half, so reduce them before the register
   logic s1_sticky_q;
   logic s2_sticky_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         s1_sticky_q <= 1'b0;
         s2_sticky_q <= 1'b0;
      end else begin
         if (accept)
            s1_sticky_q <= |lo_sum[PARM_MANT-1:0];
         if (s2_adv)
            s2_sticky_q <= s1_sticky_q;
      end
   end

   assign sticky_o = s2_sticky_q;
`endif

   assign valid_o       = s2_valid_q;
   assign product_o     = s2_prod_q;
   assign product_msb_o = s2_prod_q[PW-1];
   assign carry_drop_o  = s2_drop_q;

endmodule

// File: tb/tb_mult_cpa_stage.sv
// tb/tb_mult_cpa_stage.sv - directed table-driven bench for mult_cpa_stage
module tb_mult_cpa_stage;

   logic        clk;
   logic        rst_i;
   logic        flush_i;
   logic        valid_i;
   logic        ready_o;
   logic [48:0] wallace_sum_i;
   logic [48:0] wallace_carry_i;
   logic        supp_i;
   logic        valid_o;
   logic        ready_i;
   logic [47:0] product_o;
   logic        product_msb_o;
   logic        carry_drop_o;
`ifdef MULT_CPA_STICKY_EN
   logic        sticky_o;
`endif

   int tests = 0;
   int fails = 0;

   mult_cpa_stage #(.PARM_MANT(23), .PARM_LOW_W(24)) dut (
      .clk_i                        (clk),
      .rst_i                        (rst_i),
      .flush_i                      (flush_i),
      .valid_i                      (valid_i),
      .ready_o                      (ready_o),
      .wallace_sum_i                (wallace_sum_i),
      .wallace_carry_i              (wallace_carry_i),
      .suppression_sign_extension_i (supp_i),
      .valid_o                      (valid_o),
      .ready_i                      (ready_i),
      .product_o                    (product_o),
      .product_msb_o                (product_msb_o),
      .carry_drop_o                 (carry_drop_o)
`ifdef MULT_CPA_STICKY_EN
      ,
      .sticky_o                     (sticky_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [48:0] sum;
      logic [48:0] car;
      logic        supp;
      logic [47:0] prod;
      logic        msb;
      logic        drop;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [48:0] s, input logic [48:0] c, input logic sp, input logic v);
      wallace_sum_i   = s;
      wallace_carry_i = c;
      supp_i          = sp;
      valid_i         = v;
   endtask

   logic [47:0] got_q[$];
   logic [47:0] first_prod;
   int          acc;
   int          seen;

   initial begin
      vecs[0] = '{49'h0400000000000, 49'h0000000000000, 1'b0, 48'h400000000000, 1'b0, 1'b0};
      vecs[1] = '{49'h0000000FFFFFF, 49'h0000000000001, 1'b0, 48'h000001000000, 1'b0, 1'b0};
      vecs[2] = '{49'h1FFFFFFFFFFFF, 49'h0000000000001, 1'b0, 48'h000000000000, 1'b0, 1'b0};
      vecs[3] = '{49'h1000000000000, 49'h0000000000000, 1'b1, 48'h000000000000, 1'b0, 1'b0};
      vecs[4] = '{49'h1000000000000, 49'h0000000000000, 1'b0, 48'h000000000000, 1'b0, 1'b1};
      vecs[5] = '{49'h0800000000000, 49'h0000000000000, 1'b0, 48'h800000000000, 1'b1, 1'b0};
      vecs[6] = '{49'h0123456789ABC, 49'h0FEDCBA987654, 1'b0, 48'h111111111110, 1'b0, 1'b1};

      rst_i = 1'b1; flush_i = 1'b0; ready_i = 1'b1;
      drive('0, '0, 1'b0, 1'b0);
      step(); step();
      rst_i = 1'b0;
      check("rst_valid", valid_o, 0);
      check("rst_prod", product_o, 0);
      check("rst_msb", product_msb_o, 0);
      check("rst_drop", carry_drop_o, 0);
      check("rst_ready", ready_o, 1);

      for (int i = 0; i < 7; i++) begin
         ready_i = 1'b1;
         drive(vecs[i].sum, vecs[i].car, vecs[i].supp, 1'b1);
         #1;
         check($sformatf("v%0d_ready", i), ready_o, 1);
         step();
         drive('0, '0, 1'b0, 1'b0);
         check($sformatf("v%0d_lat1", i), valid_o, 0);
         step();
         check($sformatf("v%0d_valid", i), valid_o, 1);
         check($sformatf("v%0d_prod", i), product_o, vecs[i].prod);
         check($sformatf("v%0d_msb", i), product_msb_o, vecs[i].msb);
         check($sformatf("v%0d_drop", i), carry_drop_o, vecs[i].drop);
`ifdef MULT_CPA_STICKY_EN
         check($sformatf("v%0d_sticky", i), sticky_o, |vecs[i].prod[22:0]);
`endif
      end
      step(); step();

      // backpressure: four items offered while downstream is stalled
      acc = 0;
      ready_i = 1'b0;
      for (int c = 0; c < 5; c++) begin
         drive(49'(acc * 256 + 1), 49'(acc), 1'b0, acc < 4);
         #1;
         if (valid_i && ready_o) acc++;
         step();
      end
      check("bp_accepted", acc, 2);
      check("bp_ready_low", ready_o, 0);
      check("bp_valid", valid_o, 1);
      first_prod = product_o;
      check("bp_first", first_prod, 48'h000000000001);
      step(); step();
      check("bp_stable", product_o, 48'h000000000001);
      ready_i = 1'b1;
      for (int c = 0; c < 20; c++) begin
         drive(49'(acc * 256 + 1), 49'(acc), 1'b0, acc < 4);
         #1;
         if (valid_o && ready_i) got_q.push_back(product_o);
         if (valid_i && ready_o) acc++;
         step();
      end
      check("bp_count", got_q.size(), 4);
      for (int k = 0; k < 4; k++) begin
         if (k < got_q.size())
            check($sformatf("bp_order%0d", k), got_q[k], 48'(k * 257 + 1));
      end

      // flush with two items in flight and a third offered alongside
      ready_i = 1'b0;
      for (int c = 0; c < 2; c++) begin
         drive(49'h0000000000100, 49'(c), 1'b0, 1'b1);
         step();
      end
      check("fl_pre_valid", valid_o, 1);
      flush_i = 1'b1;
      drive(49'h0000000000200, 49'h0, 1'b0, 1'b1);
      step();
      flush_i = 1'b0;
      drive('0, '0, 1'b0, 1'b0);
      check("fl_valid", valid_o, 0);
      check("fl_ready", ready_o, 1);
      ready_i = 1'b1;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         if (valid_o) seen++;
         step();
      end
      check("fl_emitted", seen, 0);

      // reset mid-stream with nonzero outputs showing
      ready_i = 1'b0;
      for (int c = 0; c < 2; c++) begin
         drive(49'h1800000000000, 49'h0, 1'b0, 1'b1);
         step();
      end
      check("rs_pre_drop", carry_drop_o, 1);
      check("rs_pre_msb", product_msb_o, 1);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      drive('0, '0, 1'b0, 1'b0);
      check("rs_valid", valid_o, 0);
      check("rs_prod", product_o, 0);
      check("rs_msb", product_msb_o, 0);
      check("rs_drop", carry_drop_o, 0);
      check("rs_ready", ready_o, 1);
      ready_i = 1'b1;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         if (valid_o) seen++;
         step();
      end
      check("rs_emitted", seen, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
